rc_adder_sweep_ctrl: RTL
========================

Name: rc_adder_sweep_ctrl

Overview:
- Sequencer for exhaustive error characterisation of one approximate ripple-carry adder (the device under characterisation, DUC).
- Steps the DUC's two operand inputs through every (a,b) pair in turn, one pair per clock.
- Compares each DUC sum against the exact sum and accumulates the error count, the summed absolute error (for MAE) and the worst-case error with its operands.
- Sits beside the DUC in the characterisation harness; the DUC is combinational and outside this block.

Parameters:
- W, 8, operand width of the DUC. Sweep length is 2^(2W) pairs.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin sweep; sampled in IDLE only.
- abort  in  1  stop sweep; sampled in SWEEP only.
- duc_a  out  W  operand A driven to DUC (IN1).
- duc_b  out  W  operand B driven to DUC (IN2).
- duc_sum  in  W+1  DUC result (Out), combinational from duc_a/duc_b.
- busy  out  1  high while in SWEEP.
- done  out  1  one-cycle pulse when a full sweep completes.
- err_cnt  out  2W+1  number of pairs with duc_sum != a+b.
- err_sum  out  3W+1  sum over pairs of |duc_sum - (a+b)|.
- err_max  out  W+1  largest absolute error seen.
- max_a  out  W  operand A of the first pair reaching err_max.
- max_b  out  W  operand B of the first pair reaching err_max.

Behaviour:
- Reset: state=IDLE; all outputs 0, including duc_a/duc_b, busy, done and all accumulators. Reset mid-sweep abandons the sweep and clears everything.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - start=1 -> clear err_cnt/err_sum/err_max/max_a/max_b, set duc_a=duc_b=0, next state SWEEP.
  - Otherwise hold everything; results of the last sweep stay visible.
- SWEEP, every cycle:
  - exact = zero-extended duc_a + duc_b (W+1 bits).
  - e = |duc_sum - exact|, computed as an unsigned W+1-bit magnitude with no wrap.
  - If e != 0: err_cnt += 1.
  - err_sum += e.
  - If e > err_max (strictly): err_max = e, max_a = duc_a, max_b = duc_b. Ties keep the earlier pair.
  - Pair order: duc_b increments each cycle; when duc_b wraps from all-ones to 0, duc_a increments.
  - When duc_a = duc_b = all-ones, that pair is accumulated and the next state is DONE; operands return to 0.
- abort in SWEEP:
  - Takes priority over accumulation that cycle; the current pair is not accumulated.
  - Next state IDLE; operands go to 0; accumulators hold partial values; done is not pulsed.
- start is ignored in SWEEP and DONE. abort is ignored in IDLE and DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Timing: start sampled at edge t -> busy high for cycles t+1 .. t+2^(2W), done high in cycle t+2^(2W)+1. For W=8 this is 65536 evaluation cycles.
- Accumulators are sized so they never overflow: err_cnt max 2^(2W), err_sum max 2^(2W)*(2^(W+1)-1). Saturation logic is not required.
- done and busy are never high together.

Test Plan:
- Exact-adder stub (duc_sum=a+b), W=8: pulse start -> busy for 65536 cycles, done pulse in the 65537th cycle; err_cnt=0, err_sum=0, err_max=0, max_a=max_b=0.
- Stub forcing duc_sum[0]=0, W=8 -> err_cnt=32768, err_sum=32768, err_max=1, max_a=0, max_b=1.
- Stub duc_sum=0, W=8 -> err_cnt=65535, err_sum=16711680, err_max=510, max_a=255, max_b=255.
- Abort and start-in-SWEEP, W=2 with duc_sum=0:
  - Start, then abort on the 5th SWEEP cycle (pair a=1,b=0) -> only pairs (0,0..3) accumulated: err_cnt=3, err_sum=6, err_max=3 at (0,3); no done pulse; IDLE next cycle.
  - start pulsed again mid-sweep -> no restart.
- Reset at sweep cycle 1000, W=8 -> next cycle all outputs 0, state IDLE. A following start runs a full 65536-cycle sweep with correct totals.
- Back-to-back sweeps: start held high continuously, exact stub, W=2 -> done every 18 cycles (16 SWEEP + DONE + IDLE); accumulators cleared at each new start.

Source files
------------

// File: rtl/rc_adder_sweep_ctrl.sv
// Exhaustive operand sweep and error accumulator for one approximate
// ripple-carry adder; the adder itself sits outside, driven by duc_a/duc_b.
module rc_adder_sweep_ctrl #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [W-1:0]     duc_a,
  output logic [W-1:0]     duc_b,
  input  logic [W:0]       duc_sum,
  output logic             busy,
  output logic             done,
  output logic [2*W:0]     err_cnt,
  output logic [3*W:0]     err_sum,
  output logic [W:0]       err_max,
  output logic [W-1:0]     max_a,
  output logic [W-1:0]     max_b
);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t state;

  logic [W:0]     exact;
  logic [W:0]     e;
  logic           last;
  logic [2*W-1:0] pair_nxt;

  // Magnitude is taken before subtracting so it never wraps.
  always_comb begin
    exact    = {1'b0, duc_a} + {1'b0, duc_b};
    e        = (duc_sum >= exact) ? (duc_sum - exact)
                                  : (exact - duc_sum);
    last     = (&duc_a) && (&duc_b);
    pair_nxt = {duc_a, duc_b} + {{(2*W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      duc_a   <= '0;
      duc_b   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err_cnt <= '0;
      err_sum <= '0;
      err_max <= '0;
      max_a   <= '0;
      max_b   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= SWEEP;
            busy    <= 1'b1;
            duc_a   <= '0;
            duc_b   <= '0;
            err_cnt <= '0;
            err_sum <= '0;
            err_max <= '0;
            max_a   <= '0;
            max_b   <= '0;
          end
        end
        SWEEP: begin
          if (abort) begin
            // Partial totals stay visible; current pair is dropped.
            state <= IDLE;
            busy  <= 1'b0;
            duc_a <= '0;
            duc_b <= '0;
          end else begin
            if (e != '0)
              err_cnt <= err_cnt
                + {{(2*W){1'b0}}, 1'b1};
            err_sum <= err_sum + {{(2*W){1'b0}}, e};
            if (e > err_max) begin
              err_max <= e;
              max_a   <= duc_a;
              max_b   <= duc_b;
            end
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              duc_a <= '0;
              duc_b <= '0;
            end else begin
              {duc_a, duc_b} <= pair_nxt;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
